// File: rtl/i_buffer_warp.sv
// Four-entry in-order instruction buffer between decode and issue.
// Entry 0 is the oldest. Valid entries are always packed from entry 0 upward.
// When an entry issues, every entry above it moves down one slot.
module i_buffer_warp (
    input  logic        clk,
    input  logic        rst,
    // decode side
    input  logic        ID_Valid_IB,
    input  logic [5:0]  ID_Src1_IB,
    input  logic [5:0]  ID_Src2_IB,
    input  logic [5:0]  ID_Dst_IB,
    input  logic [15:0] ID_Info_IB,
    output logic        IB_Ready_ID,
    input  logic        Flush_IB,
    // scoreboard side
    output logic [3:0]  IB_Inst_Valid_SB,
    output logic [5:0]  IB_Src1_Entry0_SB,
    output logic [5:0]  IB_Src1_Entry1_SB,
    output logic [5:0]  IB_Src1_Entry2_SB,
    output logic [5:0]  IB_Src1_Entry3_SB,
    output logic [5:0]  IB_Src2_Entry0_SB,
    output logic [5:0]  IB_Src2_Entry1_SB,
    output logic [5:0]  IB_Src2_Entry2_SB,
    output logic [5:0]  IB_Src2_Entry3_SB,
    output logic [5:0]  IB_Dst_Entry0_SB,
    output logic [5:0]  IB_Dst_Entry1_SB,
    output logic [5:0]  IB_Dst_Entry2_SB,
    output logic [5:0]  IB_Dst_Entry3_SB,
    input  logic [3:0]  SB_Ready_Issue_IB,
    input  logic        SB_Full,
    // issue side
    output logic [3:0]  IB_Ready_Issue,
    input  logic [3:0]  Issue_Grant_IB,
    output logic [3:0]  IB_Issued_SB,
    output logic [15:0] IB_Info_Issue,
    output logic [5:0]  IB_Dst_Issue
);

    localparam int DEPTH = 4;

    // Entry state
    logic [3:0]  valid_reg;
    logic [3:0]  ready_reg;
    logic [5:0]  src1_reg [DEPTH];
    logic [5:0]  src2_reg [DEPTH];
    logic [5:0]  dst_reg  [DEPTH];
    logic [15:0] info_reg [DEPTH];

    // Next-state values for the non-flush, non-reset case
    logic [3:0]  valid_next;
    logic [3:0]  ready_next;
    logic [5:0]  src1_next [DEPTH];
    logic [5:0]  src2_next [DEPTH];
    logic [5:0]  dst_next  [DEPTH];
    logic [15:0] info_next [DEPTH];

    // Values after the optional removal shift, before the write is merged in
    logic [3:0]  valid_shift;
    logic [5:0]  src1_shift [DEPTH];
    logic [5:0]  src2_shift [DEPTH];
    logic [5:0]  dst_shift  [DEPTH];
    logic [15:0] info_shift [DEPTH];

    logic        full;
    logic [3:0]  ready_issue;
    logic        grant_onehot;
    logic [3:0]  issued;
    logic        removal;
    logic [3:0]  shift_sel;
    logic [2:0]  valid_count;
    logic [2:0]  wr_idx;
    logic        wr_en;

    // Fullness and readiness come from registered state only
    assign full         = &valid_reg;
    assign IB_Ready_ID  = ~full;
    assign ready_issue  = ready_reg & valid_reg;
    assign IB_Ready_Issue = ready_issue;

    // A grant is honoured only when it is exactly one-hot and nothing blocks issue
    assign grant_onehot = (Issue_Grant_IB != 4'd0) &&
                          ((Issue_Grant_IB & (Issue_Grant_IB - 4'd1)) == 4'd0);
    assign issued       = (grant_onehot && !SB_Full && !Flush_IB && !rst) ?
                          (Issue_Grant_IB & ready_issue) : 4'd0;
    assign removal      = |issued;
    assign IB_Issued_SB = issued;

    // A write is never accepted while full, even alongside an issue
    assign wr_en = ID_Valid_IB & ~full;

    // Count valid entries; the write lands just above the survivors of any removal
    always_comb begin
        valid_count = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_count = valid_count + {2'b00, valid_reg[i]};
        end
        wr_idx = valid_count - {2'b00, removal};
    end

    // Payload and destination of the issuing entry; zero when nothing issues
    always_comb begin
        IB_Info_Issue = 16'd0;
        IB_Dst_Issue  = 6'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issued[i]) begin
                IB_Info_Issue = info_reg[i];
                IB_Dst_Issue  = dst_reg[i];
            end
        end
    end

    // Per-entry shift, write merge and ready update
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry gi moves down when the removed entry is at or below it
            assign shift_sel[gi] = |issued[gi:0];

            if (gi < DEPTH - 1) begin : g_mid
                assign valid_shift[gi] = shift_sel[gi] ? valid_reg[gi+1] : valid_reg[gi];
                assign src1_shift[gi]  = shift_sel[gi] ? src1_reg[gi+1]  : src1_reg[gi];
                assign src2_shift[gi]  = shift_sel[gi] ? src2_reg[gi+1]  : src2_reg[gi];
                assign dst_shift[gi]   = shift_sel[gi] ? dst_reg[gi+1]   : dst_reg[gi];
                assign info_shift[gi]  = shift_sel[gi] ? info_reg[gi+1]  : info_reg[gi];
            end else begin : g_top
                // The top slot has nothing above it, so it empties on a shift
                assign valid_shift[gi] = shift_sel[gi] ? 1'b0  : valid_reg[gi];
                assign src1_shift[gi]  = shift_sel[gi] ? 6'd0  : src1_reg[gi];
                assign src2_shift[gi]  = shift_sel[gi] ? 6'd0  : src2_reg[gi];
                assign dst_shift[gi]   = shift_sel[gi] ? 6'd0  : dst_reg[gi];
                assign info_shift[gi]  = shift_sel[gi] ? 16'd0 : info_reg[gi];
            end

            logic wr_here;
            assign wr_here = wr_en && (wr_idx == 3'(gi));

            assign valid_next[gi] = wr_here ? 1'b1       : valid_shift[gi];
            assign src1_next[gi]  = wr_here ? ID_Src1_IB : src1_shift[gi];
            assign src2_next[gi]  = wr_here ? ID_Src2_IB : src2_shift[gi];
            assign dst_next[gi]   = wr_here ? ID_Dst_IB  : dst_shift[gi];
            assign info_next[gi]  = wr_here ? ID_Info_IB : info_shift[gi];

            // Any removal invalidates the per-slot hazard view, so all ready bits drop
            // for one edge; a freshly written slot was invalid, so it loads 0 here too.
            assign ready_next[gi] = removal ? 1'b0 : (SB_Ready_Issue_IB[gi] & valid_reg[gi]);
        end
    endgenerate

    // State update: reset beats flush, flush beats issue and write
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 4'd0;
            ready_reg <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                src1_reg[i] <= 6'd0;
                src2_reg[i] <= 6'd0;
                dst_reg[i]  <= 6'd0;
                info_reg[i] <= 16'd0;
            end
        end else if (Flush_IB) begin
            valid_reg <= 4'd0;
            ready_reg <= 4'd0;
        end else begin
            valid_reg <= valid_next;
            ready_reg <= ready_next;
            for (int i = 0; i < DEPTH; i++) begin
                src1_reg[i] <= src1_next[i];
                src2_reg[i] <= src2_next[i];
                dst_reg[i]  <= dst_next[i];
                info_reg[i] <= info_next[i];
            end
        end
    end

    // Entry fields go to the scoreboard straight from registers
    assign IB_Inst_Valid_SB  = valid_reg;
    assign IB_Src1_Entry0_SB = src1_reg[0];
    assign IB_Src1_Entry1_SB = src1_reg[1];
    assign IB_Src1_Entry2_SB = src1_reg[2];
    assign IB_Src1_Entry3_SB = src1_reg[3];
    assign IB_Src2_Entry0_SB = src2_reg[0];
    assign IB_Src2_Entry1_SB = src2_reg[1];
    assign IB_Src2_Entry2_SB = src2_reg[2];
    assign IB_Src2_Entry3_SB = src2_reg[3];
    assign IB_Dst_Entry0_SB  = dst_reg[0];
    assign IB_Dst_Entry1_SB  = dst_reg[1];
    assign IB_Dst_Entry2_SB  = dst_reg[2];
    assign IB_Dst_Entry3_SB  = dst_reg[3];

endmodule
